alu_bist: RTL and testbench

Built-in self-test engine for the combinational `alu` block. It generates pseudo-random operands for each of the 12 ALU opcodes and drives them onto the ALU's A/B/Opcode inputs. It reads back C and Flags and compresses every response into a multiple-input signature register (MISR). It sits beside the datapath ALU and is selected in test mode, so the ALU can be checked on silicon/FPGA without the simulation bench.

---
 rtl/alu_bist_pkg.sv | 29 ++
 rtl/alu_bist_if.sv | 10 +
 rtl/alu_bist_lfsr16.sv | 19 +
 rtl/alu_bist.sv | 83 ++++++++
 tb/tb_alu_bist.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_bist_pkg.sv
// alu_defs: opcode table, LFSR/MISR constants and FSM encoding shared by the ALU BIST and the ALU bench
package alu_defs;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDI = 8'h50;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_SUBI = 8'h90;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_CMPI = 8'hB0;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_ANDI = 8'h10;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_ORI  = 8'h20;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_XORI = 8'h30;
  localparam int NUM_OPS = 12;
  localparam logic [7:0] OP_TABLE [NUM_OPS] = '{
    OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_CMP, OP_CMPI,
    OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_XOR, OP_XORI
  };
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int MISR_W = 21;
  localparam int MISR_TAP_HI = 20;
  localparam int MISR_TAP_LO = 18;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SAMPLE, S_DONE} state_e;
  // Immediate forms carry the opcode in the high nibble, leaving the low nibble zero
  function automatic logic is_imm(input logic [7:0] op);
    return op[3:0] == 4'h0;
  endfunction
endpackage

// File: rtl/alu_bist_if.sv
// alu_bist_if: operand/result bundle between the BIST engine (master) and the ALU (slave)
interface alu_bist_if;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;
  modport master (output alu_a, alu_b, alu_opcode, input alu_c, alu_flags);
  modport slave (input alu_a, alu_b, alu_opcode, output alu_c, alu_flags);
endinterface

// File: rtl/alu_bist_lfsr16.sv
// lfsr16: 16-bit right-shifting Galois LFSR with synchronous reseed and advance enable
module lfsr16
  import alu_defs::*;
#(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [15:0] q_o
);
  logic [15:0] q_q, q_d;
  always_comb q_d = load_i ? SEED : adv_i ? ({1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_MASK : 16'h0)) : q_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= SEED;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/alu_bist.sv
// alu_bist: drives pseudo-random vectors through all 12 ALU opcodes and compresses the responses into a 21-bit MISR
module alu_bist
  import alu_defs::*;
#(
  parameter int          VECTORS_PER_OP = 16,
  parameter logic [15:0] SEED_A = 16'hACE1,
  parameter logic [15:0] SEED_B = 16'h1D2B
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [20:0]  expected_sig,
  alu_bist_if.master   alu,
  output logic         busy,
  output logic         done,
  output logic [20:0]  signature,
  output logic         pass
);
  localparam logic [7:0] LAST_VEC = 8'(VECTORS_PER_OP - 1);
  localparam logic [3:0] LAST_OP = 4'(NUM_OPS - 1);
  state_e state_q;
  logic [7:0] vec_q;
  logic [3:0] op_q;
  logic [15:0] a_q, b_q, lfsr_a, lfsr_b;
  logic [7:0] opc_q;
  logic [MISR_W-1:0] sig_q;
  logic busy_q, done_q, accept, advance, last_vec;
  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);
  assign advance = state_q == S_SAMPLE;
  assign last_vec = vec_q == LAST_VEC;
  lfsr16 #(.SEED(SEED_A)) u_lfsr_a (.clk(clk), .rst(rst), .load_i(accept), .adv_i(advance), .q_o(lfsr_a));
  lfsr16 #(.SEED(SEED_B)) u_lfsr_b (.clk(clk), .rst(rst), .load_i(accept), .adv_i(advance), .q_o(lfsr_b));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      opc_q <= '0;
      sig_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          a_q <= lfsr_a;
          b_q <= is_imm(OP_TABLE[op_q]) ? {{8{lfsr_b[7]}}, lfsr_b[7:0]} : lfsr_b;
          opc_q <= OP_TABLE[op_q];
          busy_q <= 1'b1;
          state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          sig_q <= {sig_q[MISR_W-2:0], sig_q[MISR_TAP_HI] ^ sig_q[MISR_TAP_LO]} ^ {alu.alu_flags, alu.alu_c};
          vec_q <= last_vec ? '0 : vec_q + 8'd1;
          op_q <= last_vec ? op_q + 4'd1 : op_q;
          state_q <= (last_vec && op_q == LAST_OP) ? S_DONE : S_LOAD;
        end
        default: begin
          // done/busy settle one edge after the final absorb; an accepted start overrides them
          if (state_q == S_DONE) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
          if (accept) begin
            state_q <= S_LOAD;
            vec_q <= '0;
            op_q <= '0;
            sig_q <= '0;
            done_q <= 1'b0;
          end
        end
      endcase
    end
  end
  assign alu.alu_a = a_q;
  assign alu.alu_b = b_q;
  assign alu.alu_opcode = opc_q;
  assign busy = busy_q;
  assign done = done_q;
  assign signature = sig_q;
  assign pass = done_q && sig_q == expected_sig;
endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: directed vector table plus reset/restart/fault-injection sequences against a stub ALU
module tb_alu_bist;
  logic clk = 1'b0, rst = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [20:0] exp1 = '0, exp2 = '0, sig1, sig2;
  logic busy1, done1, pass1, busy2, done2, pass2;
  bit mode = 1'b0, flip_en = 1'b0;
  logic [15:0] flip_a = '0;
  int checks = 0, failures = 0, cur = 0;
  logic [7:0] ops [12] = '{8'h05, 8'h50, 8'h09, 8'h90, 8'h0B, 8'hB0, 8'h01, 8'h10, 8'h02, 8'h20, 8'h03, 8'h30};

  typedef struct {int v; int k; logic [7:0] op; logic [15:0] a; logic [15:0] b;} vec_t;
  vec_t tv [8];

  alu_bist_if if1 ();
  alu_bist_if if2 ();

  alu_bist #(.VECTORS_PER_OP(1)) dut1 (.clk(clk), .rst(rst), .start(start1), .expected_sig(exp1), .alu(if1),
    .busy(busy1), .done(done1), .signature(sig1), .pass(pass1));
  alu_bist #(.VECTORS_PER_OP(3)) dut2 (.clk(clk), .rst(rst), .start(start2), .expected_sig(exp2), .alu(if2),
    .busy(busy2), .done(done2), .signature(sig2), .pass(pass2));

  always #5 clk = ~clk;

  function automatic logic [15:0] stub_c(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op, input bit m);
    return m ? (a + b) ^ {op, op} : a;
  endfunction
  function automatic logic [4:0] stub_f(input logic [15:0] b, input logic [7:0] op, input bit m);
    return m ? op[4:0] ^ b[4:0] : 5'h0;
  endfunction
  function automatic logic [15:0] lfsr_nx(input logic [15:0] q);
    return {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0);
  endfunction

  always_comb begin
    if1.alu_c = stub_c(if1.alu_a, if1.alu_b, if1.alu_opcode, mode);
    if1.alu_flags = stub_f(if1.alu_b, if1.alu_opcode, mode) ^ {4'b0, flip_en && if1.alu_a == flip_a};
    if2.alu_c = stub_c(if2.alu_a, if2.alu_b, if2.alu_opcode, mode);
    if2.alu_flags = stub_f(if2.alu_b, if2.alu_opcode, mode);
  end

  function automatic logic [15:0] model_a(input int k);
    logic [15:0] a = 16'hACE1;
    for (int i = 0; i < k; i++) a = lfsr_nx(a);
    return a;
  endfunction

  function automatic logic [20:0] model_sig(input int v, input bit m, input int flip_k);
    logic [15:0] a = 16'hACE1, b = 16'h1D2B, bo;
    logic [7:0] op;
    logic [4:0] f;
    logic [20:0] s = '0;
    for (int k = 0; k < 12 * v; k++) begin
      op = ops[k / v];
      bo = (op[3:0] == 4'h0) ? {{8{b[7]}}, b[7:0]} : b;
      f = stub_f(bo, op, m) ^ {4'b0, k == flip_k};
      s = {s[19:0], s[20] ^ s[18]} ^ {f, stub_c(a, bo, op, m)};
      a = lfsr_nx(a);
      b = lfsr_nx(b);
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_start(input bit sel);
    @(negedge clk);
    start1 = !sel;
    start2 = sel;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    cur = 0;
  endtask

  task automatic wait_done(input bit sel, input int exp_lat);
    int n = 0;
    while (!(sel ? done2 : done1) && n < exp_lat + 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", cur + n, exp_lat);
    cur = cur + n;
  endtask

  task automatic run_table(input bit sel);
    int v = sel ? 3 : 1;
    for (int i = 0; i < 8; i++) begin
      if (tv[i].v != v) continue;
      repeat (1 + 2 * tv[i].k - cur) @(negedge clk);
      cur = 1 + 2 * tv[i].k;
      chk($sformatf("v%0d_k%0d_opcode", v, tv[i].k), sel ? if2.alu_opcode : if1.alu_opcode, tv[i].op);
      chk($sformatf("v%0d_k%0d_a", v, tv[i].k), sel ? if2.alu_a : if1.alu_a, tv[i].a);
      chk($sformatf("v%0d_k%0d_b", v, tv[i].k), sel ? if2.alu_b : if1.alu_b, tv[i].b);
      chk("busy_running", sel ? busy2 : busy1, 1'b1);
      if (!sel && tv[i].k == 0 && !mode) begin
        @(negedge clk);
        cur = 2;
        chk("first_misr_update", sig1, 21'h0ACE1);
      end
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_a", if1.alu_a, 16'h0);
    chk("rst_b", if1.alu_b, 16'h0);
    chk("rst_opcode", if1.alu_opcode, 8'h0);
    chk("rst_sig", sig1, 21'h0);
    chk("rst_busy_done_pass", {busy1, done1, pass1}, 3'b000);
  endtask

  initial begin
    tv[0] = '{1, 0, 8'h05, 16'hACE1, 16'h1D2B};
    tv[1] = '{1, 1, 8'h50, 16'hE270, 16'hFF95};
    tv[2] = '{1, 2, 8'h09, 16'h7138, 16'hE94A};
    tv[3] = '{1, 3, 8'h90, 16'h389C, 16'hFFA5};
    tv[4] = '{1, 4, 8'h0B, 16'h1C4E, 16'h8E52};
    tv[5] = '{1, 5, 8'hB0, 16'h0E27, 16'h0029};
    tv[6] = '{3, 2, 8'h05, 16'h7138, 16'hE94A};
    tv[7] = '{3, 3, 8'h50, 16'h389C, 16'hFFA5};
    #3 rst = 1'b1;
    #1 chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // stub ALU passes A straight through with zero flags
    mode = 1'b0;
    exp1 = model_sig(1, 1'b0, -1);
    do_start(1'b0);
    chk("busy_before_t1", busy1, 1'b0);
    run_table(1'b0);
    wait_done(1'b0, 25);
    chk("busy_after_done", busy1, 1'b0);
    chk("sig_mode0", sig1, model_sig(1, 1'b0, -1));
    chk("pass_match", pass1, 1'b1);
    exp1 = exp1 ^ 21'h1;
    #1 chk("pass_mismatch", pass1, 1'b0);
    mode = 1'b1;
    exp1 = model_sig(1, 1'b1, -1);
    do_start(1'b0);
    run_table(1'b0);
    repeat (3) @(negedge clk);
    cur = cur + 3;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cur++;
    wait_done(1'b0, 25);
    chk("sig_ignored_start", sig1, model_sig(1, 1'b1, -1));
    repeat (3) @(negedge clk);
    chk("done_held", {done1, pass1}, 2'b11);
    do_start(1'b0);
    chk("done_cleared_on_restart", done1, 1'b0);
    wait_done(1'b0, 25);
    chk("sig_second_run", sig1, model_sig(1, 1'b1, -1));
    do_start(1'b0);
    repeat (11) @(negedge clk);
    chk("vec5_a", if1.alu_a, 16'h0E27);
    #3 rst = 1'b1;
    #1 chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", {busy1, done1, if1.alu_opcode}, 10'h0);
    do_start(1'b0);
    wait_done(1'b0, 25);
    chk("sig_after_abort", sig1, model_sig(1, 1'b1, -1));
    flip_a = model_a(7);
    flip_en = 1'b1;
    do_start(1'b0);
    wait_done(1'b0, 25);
    flip_en = 1'b0;
    chk("sig_flipped_flag", sig1, model_sig(1, 1'b1, 7));
    chk("flip_done_no_pass", {done1, pass1}, 2'b10);
    exp2 = model_sig(3, 1'b1, -1);
    do_start(1'b1);
    run_table(1'b1);
    wait_done(1'b1, 73);
    chk("sig_v3", sig2, model_sig(3, 1'b1, -1));
    chk("pass_v3", pass2, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
